// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch path: FSM state encoding.
package fetch_queue_pkg;

    // IDLE   : no request outstanding
    // REQ    : live request, returned word is pushed into the queue
    // SQUASH : request still outstanding after a redirect, returned word is dropped
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with registered storage, push/pop/flush.
// Flush has priority over push and pop. A push and pop in the same cycle leave count unchanged.
module fetch_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 4
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       head_valid,
    output logic [W-1:0]               head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign pop_ok  = pop & (count != '0) & ~flush;
    assign push_ok = push & ~flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage write; contents need no reset because the head is gated by head_valid.
    always_ff @(posedge iCLK) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: program counter, req/ack memory read FSM and prefetch queue.
//
// Handshakes:
//   memory : oMEM_REQ is raised with oADDR and both stay stable until a posedge that sees
//            iMEM_ACK=1; iMEM_DATA is sampled on that same edge. A request is never withdrawn,
//            so a redirect while waiting moves to SQUASH and the returned word is discarded.
//   decode : a word transfers on a posedge where oINSTR_VALID & iINSTR_READY are both 1;
//            oINSTR/oINSTR_ADDR are stable while oINSTR_VALID=1 and not accepted.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0,
    parameter bit TRISTATE = 1'b1
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iENABLE,
    input  logic                    iREDIRECT,
    input  logic [AW-1:0]           iREDIRECT_ADDR,
    output logic                    oMEM_REQ,
    output wire  [AW-1:0]           oADDR,
    input  logic                    iMEM_ACK,
    input  logic [DW-1:0]           iMEM_DATA,
    output logic                    oINSTR_VALID,
    output logic [DW-1:0]           oINSTR,
    output logic [AW-1:0]           oINSTR_ADDR,
    input  logic                    iINSTR_READY,
    output state_t                  oDBG_STATE,
    output logic [$clog2(DEPTH):0]  oDBG_COUNT
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   addr_q;
    logic            mem_req_q;
    logic [CW-1:0]   count;
    logic            head_valid;
    logic [AW+DW-1:0] head_data;
    logic            push;
    logic            pop;
    logic [OW-1:0]   occ_next;
    logic            issue;

    // Redirect wins over everything: it suppresses push, pop and issue in its cycle.
    assign push = (state == ST_REQ) & iMEM_ACK & ~iREDIRECT;
    assign pop  = head_valid & iINSTR_READY & ~iREDIRECT;

    // A new request may only go out if its word is guaranteed a slot after this cycle.
    assign occ_next = OW'(count) + OW'(push) - OW'(pop);
    assign issue    = iENABLE & ~iREDIRECT & (occ_next < OW'(DEPTH));

    // Fetch FSM with registered request/address outputs and the program counter.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_IDLE;
            pc        <= AW'(RESET_PC);
            addr_q    <= '0;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iREDIRECT) begin
                        pc <= iREDIRECT_ADDR;
                    end else if (issue) begin
                        state     <= ST_REQ;
                        mem_req_q <= 1'b1;
                        addr_q    <= pc;
                    end
                end
                ST_REQ: begin
                    if (iREDIRECT) begin
                        pc <= iREDIRECT_ADDR;
                        if (iMEM_ACK) begin
                            state     <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            state <= ST_SQUASH;
                        end
                    end else if (iMEM_ACK) begin
                        pc <= pc + 1'b1;
                        if (issue) begin
                            addr_q <= pc + 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (iREDIRECT) pc <= iREDIRECT_ADDR;
                    if (iMEM_ACK) begin
                        state     <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .push       (push),
        .push_data  ({pc, iMEM_DATA}),
        .pop        (pop),
        .flush      (iREDIRECT),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign oMEM_REQ     = mem_req_q;
    assign oADDR        = (TRISTATE && !mem_req_q) ? {AW{1'bz}} : addr_q;
    assign oINSTR_VALID = head_valid;
    assign oINSTR       = head_data[DW-1:0];
    assign oINSTR_ADDR  = head_data[AW+DW-1:DW];
    assign oDBG_STATE   = state;
    assign oDBG_COUNT   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: linear sequence of steps with hand-computed expectations.
// The address bus is a pulled-up net so a released (high-Z) bus reads as all ones.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          iCLK;
    logic          iRST_N;
    logic          iENABLE;
    logic          iREDIRECT;
    logic [AW-1:0] iREDIRECT_ADDR;
    logic          oMEM_REQ;
    tri1  [AW-1:0] addr_bus;
    logic          iMEM_ACK;
    logic [DW-1:0] iMEM_DATA;
    logic          oINSTR_VALID;
    logic [DW-1:0] oINSTR;
    logic [AW-1:0] oINSTR_ADDR;
    logic          iINSTR_READY;
    state_t        dbg_state;
    logic [2:0]    dbg_count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(
        .AW       (AW),
        .DW       (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (0),
        .TRISTATE (1'b1)
    ) dut (
        .iCLK           (iCLK),
        .iRST_N         (iRST_N),
        .iENABLE        (iENABLE),
        .iREDIRECT      (iREDIRECT),
        .iREDIRECT_ADDR (iREDIRECT_ADDR),
        .oMEM_REQ       (oMEM_REQ),
        .oADDR          (addr_bus),
        .iMEM_ACK       (iMEM_ACK),
        .iMEM_DATA      (iMEM_DATA),
        .oINSTR_VALID   (oINSTR_VALID),
        .oINSTR         (oINSTR),
        .oINSTR_ADDR    (oINSTR_ADDR),
        .iINSTR_READY   (iINSTR_READY),
        .oDBG_STATE     (dbg_state),
        .oDBG_COUNT     (dbg_count)
    );

    // clock / reset
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, land 1ns after the edge
    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(oMEM_REQ), 32'd0);
        chk({tag, "_valid"}, 32'(oINSTR_VALID), 32'd0);
        chk({tag, "_instr"}, 32'(oINSTR), 32'd0);
        chk({tag, "_iaddr"}, 32'(oINSTR_ADDR), 32'd0);
        chk({tag, "_bus"},   32'(addr_bus), 32'hFFF);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        chk({tag, "_count"}, 32'(dbg_count), 32'd0);
    endtask

    initial begin
        iRST_N = 1'b1; iENABLE = 1'b0; iREDIRECT = 1'b0; iREDIRECT_ADDR = '0;
        iMEM_ACK = 1'b0; iMEM_DATA = '0; iINSTR_READY = 1'b0;
        #2 iRST_N = 1'b0;
        cyc(); cyc();
        chk_reset_outputs("reset");
        iRST_N = 1'b1;

        // ---- 1: streaming fetch, 1-cycle ack, ready=1
        iENABLE = 1'b1; iINSTR_READY = 1'b1;
        cyc();
        chk("t1_req0", 32'(oMEM_REQ), 32'd1);
        chk("t1_addr0", 32'(addr_bus), 32'h000);
        iMEM_ACK = 1'b1; iMEM_DATA = 16'hA000;
        cyc();
        chk("t1_addr1", 32'(addr_bus), 32'h001);
        chk("t1_valid1", 32'(oINSTR_VALID), 32'd1);
        chk("t1_iaddr0", 32'(oINSTR_ADDR), 32'h000);
        chk("t1_instr0", 32'(oINSTR), 32'hA000);
        iMEM_DATA = 16'hA001;
        for (int k = 2; k <= 6; k++) begin
            cyc();
            chk("t1_addr", 32'(addr_bus), 32'(k));
            chk("t1_iaddr", 32'(oINSTR_ADDR), 32'(k - 1));
            chk("t1_instr", 32'(oINSTR), 32'hA000 + 32'(k - 1));
            chk("t1_count", 32'(dbg_count), 32'd1);
            iMEM_DATA = 16'hA000 + 16'(k);
        end
        iENABLE = 1'b0;
        cyc();
        chk("t1_req_off", 32'(oMEM_REQ), 32'd0);
        chk("t1_iaddr6", 32'(oINSTR_ADDR), 32'h006);
        chk("t5_idle_bus_z", 32'(addr_bus), 32'hFFF);
        iMEM_ACK = 1'b0;
        cyc();
        chk("t1_drained", 32'(oINSTR_VALID), 32'd0);

        // ---- 2: ready=0 fills the queue to DEPTH, then stops issuing
        iINSTR_READY = 1'b0; iENABLE = 1'b1;
        cyc();
        chk("t2_req", 32'(oMEM_REQ), 32'd1);
        chk("t2_addr7", 32'(addr_bus), 32'h007);
        for (int j = 0; j < DEPTH; j++) begin
            iMEM_ACK = 1'b1; iMEM_DATA = 16'hA007 + 16'(j);
            cyc();
        end
        iMEM_ACK = 1'b0;
        chk("t2_req_full", 32'(oMEM_REQ), 32'd0);
        chk("t2_count4", 32'(dbg_count), 32'd4);
        chk("t2_head", 32'(oINSTR_ADDR), 32'h007);
        cyc();
        chk("t2_req_hold", 32'(oMEM_REQ), 32'd0);
        iINSTR_READY = 1'b1;
        cyc();
        iINSTR_READY = 1'b0;
        chk("t2_req_again", 32'(oMEM_REQ), 32'd1);
        chk("t2_addr11", 32'(addr_bus), 32'h00B);
        chk("t2_count3", 32'(dbg_count), 32'd3);
        chk("t2_head8", 32'(oINSTR_ADDR), 32'h008);

        // ---- 4: redirect with ack and pop in the same cycle (queue at full-1 + outstanding)
        iINSTR_READY = 1'b1; iMEM_ACK = 1'b1; iMEM_DATA = 16'hDEAD;
        iREDIRECT = 1'b1; iREDIRECT_ADDR = 12'hFFF;
        cyc();
        iREDIRECT = 1'b0; iMEM_ACK = 1'b0;
        chk("t4_valid", 32'(oINSTR_VALID), 32'd0);
        chk("t4_count", 32'(dbg_count), 32'd0);
        chk("t4_req", 32'(oMEM_REQ), 32'd0);
        chk("t4_state", 32'(dbg_state), 32'(ST_IDLE));

        // ---- 5: fetch at FFF wraps to 000
        cyc();
        chk("t5_req", 32'(oMEM_REQ), 32'd1);
        chk("t5_addrFFF", 32'(addr_bus), 32'hFFF);
        iMEM_ACK = 1'b1; iMEM_DATA = 16'hAFFF;
        cyc();
        chk("t5_wrap", 32'(addr_bus), 32'h000);
        chk("t5_iaddr", 32'(oINSTR_ADDR), 32'hFFF);
        chk("t5_instr", 32'(oINSTR), 32'hAFFF);

        // ---- 3: redirect during REQ, ack 3 cycles late, squashed data dropped
        iMEM_ACK = 1'b0; iREDIRECT = 1'b1; iREDIRECT_ADDR = 12'h100;
        cyc();
        iREDIRECT = 1'b0;
        chk("t3_state_sq", 32'(dbg_state), 32'(ST_SQUASH));
        chk("t3_req_held", 32'(oMEM_REQ), 32'd1);
        chk("t3_addr_held", 32'(addr_bus), 32'h000);
        chk("t3_flushed", 32'(oINSTR_VALID), 32'd0);
        cyc();
        chk("t3_req_held2", 32'(oMEM_REQ), 32'd1);
        cyc();
        iMEM_ACK = 1'b1; iMEM_DATA = 16'hBEEF;
        cyc();
        iMEM_ACK = 1'b0;
        chk("t3_req_drop", 32'(oMEM_REQ), 32'd0);
        chk("t3_no_push", 32'(oINSTR_VALID), 32'd0);
        chk("t3_count", 32'(dbg_count), 32'd0);
        cyc();
        chk("t3_req_new", 32'(oMEM_REQ), 32'd1);
        chk("t3_addr100", 32'(addr_bus), 32'h100);
        iMEM_ACK = 1'b1; iMEM_DATA = 16'hA100;
        cyc();
        iMEM_ACK = 1'b0; iENABLE = 1'b0;
        chk("t3_instr", 32'(oINSTR), 32'hA100);
        chk("t3_iaddr", 32'(oINSTR_ADDR), 32'h100);
        chk("t3_addr101", 32'(addr_bus), 32'h101);

        // ---- 6: asynchronous reset while a request is outstanding
        chk("t6_pre_state", 32'(dbg_state), 32'(ST_REQ));
        #2 iRST_N = 1'b0;
        #1;
        chk_reset_outputs("t6");
        #1 iRST_N = 1'b1;
        iENABLE = 1'b1;
        cyc();
        chk("t6_restart_req", 32'(oMEM_REQ), 32'd1);
        chk("t6_restart_addr", 32'(addr_bus), 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
